id_issue_ctrl: RTL and testbench

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

---
 rtl/id_issue_ctrl_pkg.sv | 23 ++
 rtl/id_issue_scoreboard.sv | 83 ++++++++
 rtl/id_issue_ctrl.sv | 105 ++++++++++
 tb/tb_id_issue_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the ID-stage issue controller: default sizes,
// issue FSM state encoding and a source-hazard helper.
package id_issue_ctrl_pkg;

  localparam int NREG_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 2;
  localparam int REG_IDX_W     = 5;
  localparam int NREG_MAX      = 1 << REG_IDX_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } issue_state_e;

  // A source blocks issue when it is read, is not r0 and has a write in flight.
  function automatic logic src_hit(input logic                 ren,
                                   input logic [REG_IDX_W-1:0] idx,
                                   input logic [NREG_MAX-1:0]  pend);
    return ren && (idx != '0) && pend[idx];
  endfunction

endpackage

// File: rtl/id_issue_scoreboard.sv
// Per-register pending-write counters plus the RAW/WAW hazard lookup.
// Counters sit on indices 1..NREG-1; r0 and out-of-range indices never pend.
module issue_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic                 inc_en,
  input  logic [REG_IDX_W-1:0] inc_idx,
  input  logic                 dec_en,
  input  logic [REG_IDX_W-1:0] dec_idx,
  input  logic                 chk_valid,
  input  logic                 chk_ine,
  input  logic [REG_IDX_W-1:0] reg_j,
  input  logic [REG_IDX_W-1:0] reg_k,
  input  logic [REG_IDX_W-1:0] reg_d,
  input  logic                 j_ren,
  input  logic                 k_ren,
  input  logic                 d_ren,
  input  logic                 wen,
  input  logic [REG_IDX_W-1:0] wdest,
  output logic                 stall_raw,
  output logic                 stall_waw
);

  logic [NREG_MAX-1:0] pend_vec;
  logic [NREG_MAX-1:0] full_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NREG_MAX; gi++) begin : g_reg
      if (gi > 0 && gi < NREG) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             inc_hit;
        logic             dec_hit;

        assign inc_hit = inc_en && (inc_idx == REG_IDX_W'(gi));
        // A retire against an idle counter is dropped rather than wrapping.
        assign dec_hit = dec_en && (dec_idx == REG_IDX_W'(gi)) && (cnt_q != '0);

        // Next count: flush clears, a simultaneous +1/-1 cancels out.
        always_comb begin
          cnt_d = cnt_q;
          if (clr)
            cnt_d = '0;
          else if (inc_hit && !dec_hit)
            cnt_d = cnt_q + 1'b1;
          else if (dec_hit && !inc_hit)
            cnt_d = cnt_q - 1'b1;
        end

        // Counter register.
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn)
            cnt_q <= '0;
          else
            cnt_q <= cnt_d;
        end

        assign pend_vec[gi] = |cnt_q;
        assign full_vec[gi] = &cnt_q;
      end else begin : g_none
        assign pend_vec[gi] = 1'b0;
        assign full_vec[gi] = 1'b0;
      end
    end
  endgenerate

  // Hazards look only at registered counts, so a retire unblocks one cycle later.
  always_comb begin
    stall_raw = chk_valid && !chk_ine &&
                (src_hit(j_ren, reg_j, pend_vec) ||
                 src_hit(k_ren, reg_k, pend_vec) ||
                 src_hit(d_ren, reg_d, pend_vec));
    stall_waw = chk_valid && !chk_ine && wen && (wdest != '0) && full_vec[wdest];
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: gates issue on scoreboard hazards, runs the
// RUN/HOLD/FLUSH sequencer and keeps a saturating stalled-cycle counter.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ds_valid,
  input  logic [REG_IDX_W-1:0] ds_reg_j,
  input  logic [REG_IDX_W-1:0] ds_reg_k,
  input  logic [REG_IDX_W-1:0] ds_reg_d,
  input  logic                 ds_j_ren,
  input  logic                 ds_k_ren,
  input  logic                 ds_d_ren,
  input  logic                 ds_ine,
  input  logic                 ds_wen,
  input  logic [REG_IDX_W-1:0] ds_wdest,
  input  logic                 es_allowin,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic                 flush,
  output logic                 ds_allowin,
  output logic                 ds_to_es_valid,
  output logic                 stall_raw,
  output logic                 stall_waw,
  output logic [15:0]          stall_cnt
);

  issue_state_e state_q, state_d;
  logic [15:0]  stall_cnt_q, stall_cnt_d;
  logic         issue;
  logic         stalled;

  issue_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (flush),
    .inc_en    (issue && ds_wen && (ds_wdest != '0)),
    .inc_idx   (ds_wdest),
    .dec_en    (wb_valid && (wb_dest != '0)),
    .dec_idx   (wb_dest),
    .chk_valid (ds_valid),
    .chk_ine   (ds_ine),
    .reg_j     (ds_reg_j),
    .reg_k     (ds_reg_k),
    .reg_d     (ds_reg_d),
    .j_ren     (ds_j_ren),
    .k_ren     (ds_k_ren),
    .d_ren     (ds_d_ren),
    .wen       (ds_wen),
    .wdest     (ds_wdest),
    .stall_raw (stall_raw),
    .stall_waw (stall_waw)
  );

  // Issue/handshake decode and next FSM state; nothing issues while in reset.
  always_comb begin
    issue   = resetn && ds_valid && es_allowin && !stall_raw && !stall_waw &&
              !flush && (state_q != ST_FLUSH);
    stalled = ds_valid && !issue && !flush;
    if (!resetn)
      ds_allowin = 1'b1;
    else if (state_q == ST_FLUSH)
      ds_allowin = 1'b0;
    else
      ds_allowin = !ds_valid || issue;

    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (ds_valid && !issue) state_d = ST_HOLD;
        ST_HOLD:  if (issue || !ds_valid) state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State and stall-counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ds_to_es_valid = issue;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench for id_issue_ctrl: each driven cycle pushes the reference
// model's expected outputs, which are popped and compared at the falling edge.
module tb_id_issue_ctrl;

  typedef struct packed {
    bit       rst;
    bit       v;
    bit [4:0] j, k, d;
    bit       jr, kr, dr;
    bit       ine;
    bit       wen;
    bit [4:0] wd;
    bit       ea;
    bit       wbv;
    bit [4:0] wbd;
    bit       fl;
  } stim_t;

  typedef struct packed {
    bit        issue;
    bit        allowin;
    bit        raw;
    bit        waw;
    bit [15:0] scnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ds_valid = 1'b0;
  logic [4:0]  ds_reg_j = '0, ds_reg_k = '0, ds_reg_d = '0;
  logic        ds_j_ren = 1'b0, ds_k_ren = 1'b0, ds_d_ren = 1'b0;
  logic        ds_ine = 1'b0, ds_wen = 1'b0;
  logic [4:0]  ds_wdest = '0;
  logic        es_allowin = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic        flush = 1'b0;
  logic        ds_allowin, ds_to_es_valid, stall_raw, stall_waw;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int        m_cnt[32];
  int        m_state;     // 0 run, 1 hold, 2 flush
  bit [15:0] m_scnt;
  stim_t     cur_s;
  exp_t      cur_e;
  exp_t      exp_q[$];

  id_issue_ctrl dut (
    .clk(clk), .resetn(resetn), .ds_valid(ds_valid),
    .ds_reg_j(ds_reg_j), .ds_reg_k(ds_reg_k), .ds_reg_d(ds_reg_d),
    .ds_j_ren(ds_j_ren), .ds_k_ren(ds_k_ren), .ds_d_ren(ds_d_ren),
    .ds_ine(ds_ine), .ds_wen(ds_wen), .ds_wdest(ds_wdest),
    .es_allowin(es_allowin), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .flush(flush), .ds_allowin(ds_allowin), .ds_to_es_valid(ds_to_es_valid),
    .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(bit v, bit [4:0] j, bit jr, bit wen, bit [4:0] wd,
                               bit wbv, bit [4:0] wbd, bit fl);
    stim_t s;
    s = '0;
    s.v = v; s.j = j; s.jr = jr; s.wen = wen; s.wd = wd;
    s.wbv = wbv; s.wbd = wbd; s.fl = fl; s.ea = 1'b1;
    return s;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    e.raw = s.v && !s.ine &&
            ((s.jr && s.j != 0 && m_cnt[s.j] != 0) ||
             (s.kr && s.k != 0 && m_cnt[s.k] != 0) ||
             (s.dr && s.d != 0 && m_cnt[s.d] != 0));
    e.waw = s.v && !s.ine && s.wen && s.wd != 0 && m_cnt[s.wd] == 3;
    e.issue = !s.rst && s.v && s.ea && !e.raw && !e.waw && !s.fl && m_state != 2;
    if (s.rst)             e.allowin = 1'b1;
    else if (m_state == 2) e.allowin = 1'b0;
    else                   e.allowin = !s.v || e.issue;
    e.scnt = m_scnt;
    return e;
  endfunction

  // Drive one cycle of inputs and push the model's expectation.
  task automatic apply(stim_t s);
    if (s.rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_state = 0;
      m_scnt  = '0;
    end
    resetn = !s.rst; ds_valid = s.v;
    ds_reg_j = s.j; ds_reg_k = s.k; ds_reg_d = s.d;
    ds_j_ren = s.jr; ds_k_ren = s.kr; ds_d_ren = s.dr;
    ds_ine = s.ine; ds_wen = s.wen; ds_wdest = s.wd; es_allowin = s.ea;
    wb_valid = s.wbv; wb_dest = s.wbd; flush = s.fl;
    cur_s = s;
    cur_e = predict(s);
    exp_q.push_back(cur_e);
  endtask

  // Advance the clock and the model together.
  task automatic tick();
    bit inc, dec;
    @(posedge clk);
    if (!cur_s.rst) begin
      if (cur_s.fl) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
        inc = cur_e.issue && cur_s.wen && cur_s.wd != 0;
        dec = cur_s.wbv && cur_s.wbd != 0 && m_cnt[cur_s.wbd] > 0;
        if (!(inc && dec && cur_s.wd == cur_s.wbd)) begin
          if (inc) m_cnt[cur_s.wd]++;
          if (dec) m_cnt[cur_s.wbd]--;
        end
      end
      if (cur_s.v && !cur_e.issue && !cur_s.fl && m_scnt != 16'hFFFF) m_scnt++;
      if (cur_s.fl)                         m_state = 2;
      else if (m_state == 2)                m_state = 0;
      else if (m_state == 0 && cur_s.v && !cur_e.issue) m_state = 1;
      else if (m_state == 1 && (cur_e.issue || !cur_s.v)) m_state = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    s = mk(1, 5, 1, 1, 5, 0, 0, 0);
    s.rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got iss=%b alw=%b raw=%b waw=%b cnt=%h, want %b %b %b %b %h",
                 i, ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt,
                 e.issue, e.allowin, e.raw, e.waw, e.scnt);
      end
      $display("reset[%0d] alw=%b iss=%b cnt=%h", i, ds_allowin, ds_to_es_valid, stall_cnt);
      tick();
    end
  endtask

  task automatic test_raw();
    stim_t seq[$];
    stim_t s;
    exp_t  e;
    s = mk(1, 0, 0, 0, 0, 0, 0, 0); s.ea = 1'b0;
    seq.push_back(s);                                  // EX busy: no issue
    seq.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0));         // writer of r5
    repeat (3) seq.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0));
    seq.push_back(mk(1, 5, 1, 0, 0, 1, 5, 0));         // retire, no bypass
    seq.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0));         // now issues
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
        errors++;
        $display("FAIL raw[%0d]: got iss=%b alw=%b raw=%b waw=%b cnt=%h, want %b %b %b %b %h",
                 i, ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt,
                 e.issue, e.allowin, e.raw, e.waw, e.scnt);
      end
      $display("raw[%0d] iss=%b raw=%b cnt=%h", i, ds_to_es_valid, stall_raw, stall_cnt);
      tick();
    end
  endtask

  task automatic test_waw();
    stim_t seq[$];
    exp_t  e;
    repeat (3) seq.push_back(mk(1, 0, 0, 1, 7, 0, 0, 0));
    repeat (2) seq.push_back(mk(1, 0, 0, 1, 7, 0, 0, 0)); // saturated: stall
    seq.push_back(mk(1, 0, 0, 1, 7, 1, 7, 0));            // retire, still stalls
    seq.push_back(mk(1, 0, 0, 1, 7, 0, 0, 0));            // issues
    repeat (4) seq.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0)); // drain + extra retire at zero
    seq.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0));            // reader issues
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
        errors++;
        $display("FAIL waw[%0d]: got iss=%b alw=%b raw=%b waw=%b cnt=%h, want %b %b %b %b %h",
                 i, ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt,
                 e.issue, e.allowin, e.raw, e.waw, e.scnt);
      end
      $display("waw[%0d] iss=%b waw=%b cnt=%h", i, ds_to_es_valid, stall_waw, stall_cnt);
      tick();
    end
  endtask

  task automatic test_same_cycle();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 0, 0, 1, 3, 0, 0, 0));   // r3 -> 1
    seq.push_back(mk(1, 0, 0, 1, 3, 1, 3, 0));   // inc+dec cancel -> 1
    seq.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0));   // stalls
    seq.push_back(mk(1, 3, 1, 0, 0, 1, 3, 0));   // stalls, r3 -> 0
    seq.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0));   // issues
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
        errors++;
        $display("FAIL same[%0d]: got iss=%b alw=%b raw=%b waw=%b cnt=%h, want %b %b %b %b %h",
                 i, ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt,
                 e.issue, e.allowin, e.raw, e.waw, e.scnt);
      end
      $display("same[%0d] iss=%b raw=%b", i, ds_to_es_valid, stall_raw);
      tick();
    end
  endtask

  task automatic test_flush();
    stim_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 0, 0, 1, 9, 0, 0, 0));
    seq.push_back(mk(1, 0, 0, 1, 10, 0, 0, 0));
    seq.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0));    // stall -> HOLD
    seq.push_back(mk(1, 9, 1, 0, 0, 1, 10, 1));   // flush overrides retire
    seq.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0));    // FLUSH cycle
    seq.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0));    // counters clear: issues
    seq.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
        errors++;
        $display("FAIL flush[%0d]: got iss=%b alw=%b raw=%b waw=%b cnt=%h, want %b %b %b %b %h",
                 i, ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt,
                 e.issue, e.allowin, e.raw, e.waw, e.scnt);
      end
      $display("flush[%0d] iss=%b alw=%b raw=%b", i, ds_to_es_valid, ds_allowin, stall_raw);
      tick();
    end
  endtask

  task automatic test_r0_ine();
    stim_t seq[$];
    stim_t s;
    exp_t  e;
    s = mk(1, 0, 1, 1, 0, 0, 0, 0);
    s.kr = 1'b1; s.dr = 1'b1;
    repeat (5) seq.push_back(s);                  // r0 never pends
    seq.push_back(mk(1, 0, 0, 1, 12, 0, 0, 0));
    s = mk(1, 12, 1, 1, 12, 0, 0, 0); s.ine = 1'b1;
    seq.push_back(s);                             // invalid op skips check
    seq.push_back(mk(1, 12, 1, 0, 0, 0, 0, 0));   // stalls (r12 = 2)
    repeat (2) seq.push_back(mk(0, 0, 0, 0, 0, 1, 12, 0));
    seq.push_back(mk(1, 12, 1, 0, 0, 0, 0, 0));   // issues
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
        errors++;
        $display("FAIL r0ine[%0d]: got iss=%b alw=%b raw=%b waw=%b cnt=%h, want %b %b %b %b %h",
                 i, ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt,
                 e.issue, e.allowin, e.raw, e.waw, e.scnt);
      end
      $display("r0ine[%0d] iss=%b raw=%b waw=%b", i, ds_to_es_valid, stall_raw, stall_waw);
      tick();
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    exp_t  e;
    int    bad = 0;
    apply(mk(1, 0, 0, 1, 20, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (ds_to_es_valid !== e.issue) begin
      errors++;
      $display("FAIL sat_writer: got iss=%b want %b", ds_to_es_valid, e.issue);
    end
    tick();
    for (int i = 0; i < 70000; i++) begin
      apply(mk(1, 20, 1, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = exp_q.pop_front();
      if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
        bad++;
        if (bad <= 3)
          $display("FAIL sat_hold[%0d]: got iss=%b raw=%b cnt=%h, want %b %b %h",
                   i, ds_to_es_valid, stall_raw, stall_cnt, e.issue, e.raw, e.scnt);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    $display("sat_hold 70000 cycles cnt=%h", stall_cnt);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_value: got %h want ffff", stall_cnt);
    end
    // Reset mid-stall.
    s = mk(1, 20, 1, 0, 0, 0, 0, 0);
    s.rst = 1'b1;
    apply(s);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
      errors++;
      $display("FAIL sat_reset: got iss=%b alw=%b raw=%b cnt=%h, want %b %b %b %h",
               ds_to_es_valid, ds_allowin, stall_raw, stall_cnt, e.issue, e.allowin, e.raw, e.scnt);
    end
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL sat_cnt_cleared: got %h want 0000", stall_cnt);
    end
    $display("sat_reset cnt=%h alw=%b", stall_cnt, ds_allowin);
    tick();
    apply(mk(1, 20, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({ds_to_es_valid, ds_allowin, stall_raw, stall_waw, stall_cnt} !== e) begin
      errors++;
      $display("FAIL sat_after_reset: got iss=%b raw=%b cnt=%h, want %b %b %h",
               ds_to_es_valid, stall_raw, stall_cnt, e.issue, e.raw, e.scnt);
    end
    $display("sat_after_reset iss=%b raw=%b", ds_to_es_valid, stall_raw);
    tick();
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_state = 0;
    m_scnt  = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_raw();
    test_waw();
    test_same_cycle();
    test_flush();
    test_r0_ine();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
